// File: rtl/tomasulo_exe.sv
// Shared Tomasulo types plus the fixed-latency integer execution pipe that
// sits behind the reservation station and drives one reserved CDB slot.
package tomasulo_pkg;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned ROBID_W = 5;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [IMM_W-1:0]   imm_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [ROBID_W-1:0] robid_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_ADDI = 4'd7,
        OP_MOVI = 4'd8
    } opcode_t;

    typedef struct packed {
        opcode_t      op;
        word_t [1:0]  rdata;
        imm_t         imm;
        tag_t         tag;
        robid_t       robid;
    } issue_t;

    typedef struct packed {
        logic  vld;
        tag_t  tag;
        word_t wdata;
    } cdb_t;
endpackage

module tomasulo_exe
    import tomasulo_pkg::*;
#(
    parameter int unsigned LATENCY_N = 2,
    parameter int unsigned W         = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 iss_vld_r,
    input  issue_t                               iss_r,
    input  logic                                 flush,
    output cdb_t                                 cdb_r,
    output logic                                 cmp_vld_r,
    output robid_t                               cmp_robid_r,
    output logic                                 busy_r,
    output logic [$clog2(LATENCY_N+1)-1:0]       occ_r
);
    localparam int unsigned SHW   = $clog2(W);
    localparam int unsigned OCC_W = $clog2(LATENCY_N + 1);

    word_t                    alu_a;
    word_t                    alu_b;
    word_t                    imm_sx;
    logic [SHW-1:0]           shamt;
    word_t                    alu_res;

    logic [LATENCY_N-1:0]     vld_d,   vld_q;
    word_t  [LATENCY_N-1:0]   res_d,   res_q;
    tag_t   [LATENCY_N-1:0]   tag_d,   tag_q;
    robid_t [LATENCY_N-1:0]   robid_d, robid_q;
    logic [OCC_W-1:0]         occ_d,   occ_q;
    logic                     busy_d,  busy_q;

    always_comb begin
        alu_a   = iss_r.rdata[0];
        alu_b   = iss_r.rdata[1];
        imm_sx  = {{(WORD_W-IMM_W){iss_r.imm[IMM_W-1]}}, iss_r.imm};
        shamt   = alu_b[SHW-1:0];
        alu_res = '0;
        case (iss_r.op)
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_SLL:  alu_res = alu_a << shamt;
            OP_SRL:  alu_res = alu_a >> shamt;
            OP_ADDI: alu_res = alu_a + imm_sx;
            OP_MOVI: alu_res = imm_sx;
            default: alu_res = '0;
        endcase
    end

    // Payload loads only when its stage receives a valid op, so flushed or idle slots hold.
    always_comb begin
        vld_d[0] = iss_vld_r;
        for (int unsigned i = 1; i < LATENCY_N; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (flush) begin
            vld_d = '0;
        end

        res_d[0]   = vld_d[0] ? alu_res     : res_q[0];
        tag_d[0]   = vld_d[0] ? iss_r.tag   : tag_q[0];
        robid_d[0] = vld_d[0] ? iss_r.robid : robid_q[0];
        for (int unsigned i = 1; i < LATENCY_N; i++) begin
            res_d[i]   = vld_d[i] ? res_q[i-1]   : res_q[i];
            tag_d[i]   = vld_d[i] ? tag_q[i-1]   : tag_q[i];
            robid_d[i] = vld_d[i] ? robid_q[i-1] : robid_q[i];
        end

        occ_d = '0;
        for (int unsigned i = 0; i < LATENCY_N; i++) begin
            occ_d = occ_d + OCC_W'(vld_d[i]);
        end
        busy_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            occ_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            occ_q  <= occ_d;
            busy_q <= busy_d;
        end
        res_q   <= res_d;
        tag_q   <= tag_d;
        robid_q <= robid_d;
    end

    assign cdb_r       = '{vld: vld_q[LATENCY_N-1], tag: tag_q[LATENCY_N-1], wdata: res_q[LATENCY_N-1]};
    assign cmp_vld_r   = vld_q[LATENCY_N-1];
    assign cmp_robid_r = robid_q[LATENCY_N-1];
    assign busy_r      = busy_q;
    assign occ_r       = occ_q;
endmodule

// File: tb/tb_tomasulo_exe.sv
// Bench for tomasulo_exe: LATENCY_N=2 and LATENCY_N=1 instances share stimulus
// and are checked against a per-cycle broadcast schedule model.
module tb_tomasulo_exe;
    import tomasulo_pkg::*;

    localparam int MAXC = 1024;

    typedef struct {
        bit     vld;
        word_t  wd;
        tag_t   tag;
        robid_t rob;
    } ev_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   iss_vld_r;
    logic   flush;
    issue_t iss_r;

    cdb_t       cdb2, cdb1;
    logic       cmpv2, cmpv1, busy2, busy1;
    robid_t     rob2, rob1;
    logic [1:0] occ2;
    logic [0:0] occ1;

    ev_t m2 [MAXC];
    ev_t m1 [MAXC];
    int  cyc;
    int  checks;
    int  passes;

    always #5 clk = ~clk;

    tomasulo_exe #(.LATENCY_N(2), .W(32)) u_dut2 (
        .clk(clk), .rst(rst), .iss_vld_r(iss_vld_r), .iss_r(iss_r), .flush(flush),
        .cdb_r(cdb2), .cmp_vld_r(cmpv2), .cmp_robid_r(rob2), .busy_r(busy2), .occ_r(occ2)
    );

    tomasulo_exe #(.LATENCY_N(1), .W(32)) u_dut1 (
        .clk(clk), .rst(rst), .iss_vld_r(iss_vld_r), .iss_r(iss_r), .flush(flush),
        .cdb_r(cdb1), .cmp_vld_r(cmpv1), .cmp_robid_r(rob1), .busy_r(busy1), .occ_r(occ1)
    );

    function automatic word_t ref_alu(input issue_t p);
        word_t a = p.rdata[0];
        word_t b = p.rdata[1];
        word_t sx = word_t'(int'($signed(p.imm)));
        case (p.op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << (b % 32);
            OP_SRL:  return a >> (b % 32);
            OP_ADDI: return a + sx;
            OP_MOVI: return sx;
            default: return '0;
        endcase
    endfunction

    function automatic issue_t mk(input opcode_t op, input word_t a, input word_t b,
                                  input imm_t imm, input tag_t t, input robid_t r);
        issue_t p;
        p.op = op; p.rdata[0] = a; p.rdata[1] = b; p.imm = imm; p.tag = t; p.robid = r;
        return p;
    endfunction

    task automatic drive(input bit v, input issue_t p, input bit fl, input bit r);
        iss_vld_r = v;
        iss_r     = p;
        flush     = fl;
        rst       = r;
    endtask

    // Record what this cycle's inputs mean for future broadcasts, then move to the next cycle.
    task automatic advance();
        if (rst || flush) begin
            m2[cyc+1].vld = 1'b0;
            m2[cyc+2].vld = 1'b0;
            m1[cyc+1].vld = 1'b0;
        end else if (iss_vld_r) begin
            m2[cyc+2] = '{1'b1, ref_alu(iss_r), iss_r.tag, iss_r.robid};
            m1[cyc+1] = '{1'b1, ref_alu(iss_r), iss_r.tag, iss_r.robid};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        advance();
        advance();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (cdb2.vld !== 1'b0) $display("FAIL reset_vld2 got %b want 0", cdb2.vld); else passes++;
        checks++; if (cmpv2 !== 1'b0)    $display("FAIL reset_cmpv2 got %b want 0", cmpv2); else passes++;
        checks++; if (busy2 !== 1'b0)    $display("FAIL reset_busy2 got %b want 0", busy2); else passes++;
        checks++; if (occ2 !== 2'd0)     $display("FAIL reset_occ2 got %0d want 0", occ2); else passes++;
        checks++; if (cdb1.vld !== 1'b0) $display("FAIL reset_vld1 got %b want 0", cdb1.vld); else passes++;
        checks++; if (occ1 !== 1'b0)     $display("FAIL reset_occ1 got %0d want 0", occ1); else passes++;
        advance();
    endtask

    task automatic test_add();
        issue_t p = mk(OP_ADD, 32'd5, 32'd7, 16'd0, 4'd3, 5'd9);
        while (cyc < 10) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, p, 1'b0, 1'b0);
            @(negedge clk);
            if (i == 0) begin
                checks++; if (cdb2.vld !== 1'b0) $display("FAIL add_early_vld2 got %b want 0", cdb2.vld); else passes++;
            end
            if (i == 1) begin
                checks++; if (occ2 !== 2'd1)     $display("FAIL add_occ2_c11 got %0d want 1", occ2); else passes++;
                checks++; if (cdb2.vld !== 1'b0) $display("FAIL add_vld2_c11 got %b want 0", cdb2.vld); else passes++;
                checks++; if (cdb1.vld !== 1'b1 || cdb1.wdata !== 32'd12)
                    $display("FAIL add_n1 got vld=%b wd=%h want vld=1 wd=0000000c", cdb1.vld, cdb1.wdata); else passes++;
            end
            if (i == 2) begin
                checks++; if (cdb2.vld !== 1'b1)      $display("FAIL add_vld2 got %b want 1", cdb2.vld); else passes++;
                checks++; if (cdb2.tag !== 4'd3)      $display("FAIL add_tag2 got %0d want 3", cdb2.tag); else passes++;
                checks++; if (cdb2.wdata !== 32'd12)  $display("FAIL add_wd2 got %h want 0000000c", cdb2.wdata); else passes++;
                checks++; if (cmpv2 !== 1'b1)         $display("FAIL add_cmpv2 got %b want 1", cmpv2); else passes++;
                checks++; if (rob2 !== 5'd9)          $display("FAIL add_rob2 got %0d want 9", rob2); else passes++;
                checks++; if (occ2 !== 2'd1)          $display("FAIL add_occ2_c12 got %0d want 1", occ2); else passes++;
            end
            if (i == 3) begin
                checks++; if (cdb2.vld !== 1'b0 || occ2 !== 2'd0 || busy2 !== 1'b0)
                    $display("FAIL add_after got vld=%b occ=%0d busy=%b want 0/0/0", cdb2.vld, occ2, busy2); else passes++;
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        issue_t p [4];
        word_t  exp_wd [4];
        int     peak = 0;
        p[0] = mk(OP_SUB,  32'd1,          32'd2,      16'd0,     4'd1, 5'd11);
        p[1] = mk(OP_XOR,  32'h0000F0F0,   32'h0FF0,   16'd0,     4'd2, 5'd12);
        p[2] = mk(OP_SRL,  32'h80000000,   32'd31,     16'd0,     4'd3, 5'd13);
        p[3] = mk(OP_ADDI, 32'd10,         32'd0,      16'hFFFD,  4'd4, 5'd14);
        exp_wd[0] = 32'hFFFFFFFF; exp_wd[1] = 32'h0000FF00; exp_wd[2] = 32'd1; exp_wd[3] = 32'd7;
        for (int i = 0; i < 7; i++) begin
            drive(i < 4, (i < 4) ? p[i] : issue_t'('0), 1'b0, 1'b0);
            @(negedge clk);
            if (int'(occ2) > peak) peak = int'(occ2);
            if (i >= 2 && i <= 5) begin
                checks++; if (cdb2.vld !== 1'b1 || cdb2.wdata !== exp_wd[i-2] || cdb2.tag !== tag_t'(i-1))
                    $display("FAIL b2b_n2_%0d got vld=%b wd=%h tag=%0d want vld=1 wd=%h tag=%0d",
                             i-2, cdb2.vld, cdb2.wdata, cdb2.tag, exp_wd[i-2], i-1); else passes++;
            end
            if (i >= 1 && i <= 4) begin
                checks++; if (cdb1.vld !== 1'b1 || cdb1.wdata !== exp_wd[i-1])
                    $display("FAIL b2b_n1_%0d got vld=%b wd=%h want vld=1 wd=%h",
                             i-1, cdb1.vld, cdb1.wdata, exp_wd[i-1]); else passes++;
            end
            if (i == 6) begin
                checks++; if (cdb2.vld !== 1'b0) $display("FAIL b2b_tail got %b want 0", cdb2.vld); else passes++;
            end
            advance();
        end
        checks++; if (peak != 2) $display("FAIL b2b_occ_peak got %0d want 2", peak); else passes++;
    endtask

    task automatic test_shift_movi();
        issue_t p0 = mk(OP_SLL,  32'd1, 32'd33, 16'd0,     4'd5, 5'd1);
        issue_t p1 = mk(OP_MOVI, 32'd0, 32'd0,  16'h8000,  4'd6, 5'd2);
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, (i == 0) ? p0 : p1, 1'b0, 1'b0);
            @(negedge clk);
            if (i == 2) begin
                checks++; if (cdb2.vld !== 1'b1 || cdb2.wdata !== 32'd2)
                    $display("FAIL sll_mask got vld=%b wd=%h want vld=1 wd=00000002", cdb2.vld, cdb2.wdata); else passes++;
            end
            if (i == 3) begin
                checks++; if (cdb2.vld !== 1'b1 || cdb2.wdata !== 32'hFFFF8000)
                    $display("FAIL movi_sext got vld=%b wd=%h want vld=1 wd=ffff8000", cdb2.vld, cdb2.wdata); else passes++;
            end
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, mk(OP_ADD, word_t'(100 + i), 32'd1, 16'd0, tag_t'(7 + i), robid_t'(20 + i)),
                  i == 2, 1'b0);
            @(negedge clk);
            if (i == 1) begin
                checks++; if (cdb1.vld !== 1'b1 || cdb1.tag !== 4'd7)
                    $display("FAIL flush_n1_op0 got vld=%b tag=%0d want vld=1 tag=7", cdb1.vld, cdb1.tag); else passes++;
            end
            if (i == 2) begin
                checks++; if (cdb2.vld !== 1'b1 || cdb2.tag !== 4'd7 || cdb2.wdata !== 32'd101)
                    $display("FAIL flush_n2_op0 got vld=%b tag=%0d wd=%h want vld=1 tag=7 wd=00000065",
                             cdb2.vld, cdb2.tag, cdb2.wdata); else passes++;
                checks++; if (cdb1.vld !== 1'b1 || cdb1.tag !== 4'd8)
                    $display("FAIL flush_n1_op1 got vld=%b tag=%0d want vld=1 tag=8", cdb1.vld, cdb1.tag); else passes++;
            end
            if (i >= 3) begin
                checks++; if (cdb2.vld !== 1'b0 || occ2 !== 2'd0 || busy2 !== 1'b0)
                    $display("FAIL flush_n2_after%0d got vld=%b occ=%0d busy=%b want 0/0/0", i, cdb2.vld, occ2, busy2); else passes++;
                checks++; if (cdb1.vld !== 1'b0 || occ1 !== 1'b0)
                    $display("FAIL flush_n1_after%0d got vld=%b occ=%0d want 0/0", i, cdb1.vld, occ1); else passes++;
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 5; i++) begin
            drive(i == 0, mk(OP_OR, 32'h00F0, 32'h000F, 16'd0, 4'd2, 5'd3), i == 1 ? 1'b0 : 1'b0, i == 1);
            @(negedge clk);
            if (i == 1) begin
                checks++; if (occ2 !== 2'd1) $display("FAIL rstmid_occ2 got %0d want 1", occ2); else passes++;
                checks++; if (cdb1.vld !== 1'b1 || cdb1.wdata !== 32'h00FF)
                    $display("FAIL rstmid_n1 got vld=%b wd=%h want vld=1 wd=000000ff", cdb1.vld, cdb1.wdata); else passes++;
            end
            if (i >= 2) begin
                checks++; if (cdb2.vld !== 1'b0 || cmpv2 !== 1'b0 || busy2 !== 1'b0 || occ2 !== 2'd0)
                    $display("FAIL rstmid_n2_%0d got vld=%b cmpv=%b busy=%b occ=%0d want all 0",
                             i, cdb2.vld, cmpv2, busy2, occ2); else passes++;
                checks++; if (cdb1.vld !== 1'b0 || cmpv1 !== 1'b0 || busy1 !== 1'b0 || occ1 !== 1'b0)
                    $display("FAIL rstmid_n1_%0d got vld=%b cmpv=%b busy=%b occ=%0d want all 0",
                             i, cdb1.vld, cmpv1, busy1, occ1); else passes++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        issue_t p;
        bit     v, fl, r;
        int     e_occ2, e_occ1;
        for (int i = 0; i < 67; i++) begin
            p.op       = opcode_t'(4'($urandom_range(0, 11)));
            p.rdata[0] = word_t'($urandom);
            p.rdata[1] = ($urandom_range(0, 1) == 1) ? word_t'($urandom) : word_t'($urandom_range(0, 40));
            p.imm      = imm_t'($urandom);
            p.tag      = tag_t'($urandom);
            p.robid    = robid_t'($urandom);
            if (i < 16) begin
                v = 1'b1; fl = 1'b0; r = 1'b0;
            end else if (i < 64) begin
                v  = ($urandom_range(0, 9) < 7);
                fl = ($urandom_range(0, 9) == 0);
                r  = ($urandom_range(0, 29) == 0);
            end else begin
                v = 1'b0; fl = 1'b0; r = 1'b0;
            end
            drive(v, p, fl, r);
            @(negedge clk);
            e_occ2 = int'(m2[cyc].vld) + int'(m2[cyc+1].vld);
            e_occ1 = int'(m1[cyc].vld);
            checks++; if (cdb2.vld !== m2[cyc].vld || cmpv2 !== m2[cyc].vld)
                $display("FAIL rnd_vld2 c%0d got vld=%b cmpv=%b want %b", cyc, cdb2.vld, cmpv2, m2[cyc].vld); else passes++;
            checks++; if (occ2 !== 2'(e_occ2) || busy2 !== (e_occ2 != 0))
                $display("FAIL rnd_occ2 c%0d got occ=%0d busy=%b want occ=%0d", cyc, occ2, busy2, e_occ2); else passes++;
            if (m2[cyc].vld) begin
                checks++; if (cdb2.wdata !== m2[cyc].wd || cdb2.tag !== m2[cyc].tag || rob2 !== m2[cyc].rob)
                    $display("FAIL rnd_pay2 c%0d got wd=%h tag=%0d rob=%0d want wd=%h tag=%0d rob=%0d", cyc,
                             cdb2.wdata, cdb2.tag, rob2, m2[cyc].wd, m2[cyc].tag, m2[cyc].rob); else passes++;
            end
            checks++; if (cdb1.vld !== m1[cyc].vld || cmpv1 !== m1[cyc].vld)
                $display("FAIL rnd_vld1 c%0d got vld=%b cmpv=%b want %b", cyc, cdb1.vld, cmpv1, m1[cyc].vld); else passes++;
            checks++; if (occ1 !== 1'(e_occ1) || busy1 !== (e_occ1 != 0))
                $display("FAIL rnd_occ1 c%0d got occ=%0d busy=%b want occ=%0d", cyc, occ1, busy1, e_occ1); else passes++;
            if (m1[cyc].vld) begin
                checks++; if (cdb1.wdata !== m1[cyc].wd || cdb1.tag !== m1[cyc].tag || rob1 !== m1[cyc].rob)
                    $display("FAIL rnd_pay1 c%0d got wd=%h tag=%0d rob=%0d want wd=%h tag=%0d rob=%0d", cyc,
                             cdb1.wdata, cdb1.tag, rob1, m1[cyc].wd, m1[cyc].tag, m1[cyc].rob); else passes++;
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; checks = 0; passes = 0;
        for (int i = 0; i < MAXC; i++) begin
            m2[i].vld = 1'b0;
            m1[i].vld = 1'b0;
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        test_reset();
        test_add();
        test_back_to_back();
        test_shift_movi();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
